// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data SRAM between the CPU MEM stage
// and an external host port. The CPU wins by default; a host blocked for
// MAX_WAIT consecutive cycles gets one forced grant. With enable low the
// host owns the SRAM outright. Read data (1-cycle latency) is routed back
// to whichever requester issued the read.
//
// Handshake: a request is a level (cpu_req / ext_req) held with its
// address/data; it is accepted in a cycle where ext_gnt=1 (host) or
// cpu_req=1 with cpu_stall=0 (CPU). Read data arrives on the owner's
// rdata with rvalid=1 exactly one cycle after the accepting cycle.
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state,
  output logic [3:0]        dbg_wait_cnt
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_CPU   = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  owner_t     rd_owner, owner_nxt;
  logic       cpu_gnt;

  // State, starvation counter and read-owner registers.
  always_ff @(posedge clk or posedge arst_n) begin
    if (arst_n) begin
      state    <= S_LOAD;
      wait_cnt <= '0;
      rd_owner <= OWN_NONE;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      rd_owner <= owner_nxt;
    end
  end

  // Grant decision: purely from current state and requests, one winner max.
  always_comb begin
    cpu_gnt   = 1'b0;
    ext_gnt   = 1'b0;
    cpu_stall = 1'b0;
    case (state)
      S_LOAD: begin
        ext_gnt   = ext_req;
        cpu_stall = cpu_req;
      end
      S_FORCE: begin
        if (ext_req) begin
          ext_gnt   = 1'b1;
          cpu_stall = cpu_req;
        end else begin
          cpu_gnt = cpu_req;
        end
      end
      default: begin
        cpu_gnt = cpu_req;
        ext_gnt = ext_req & ~cpu_req;
      end
    endcase
  end

  // Next state and starvation counting; counter only survives in S_CPU.
  always_comb begin
    state_nxt = state;
    wait_nxt  = '0;
    if (!enable) begin
      state_nxt = S_LOAD;
    end else begin
      case (state)
        S_LOAD:  state_nxt = S_CPU;
        S_FORCE: state_nxt = S_CPU;
        S_CPU: begin
          if (ext_req && !ext_gnt) begin
            if (wait_cnt == WAIT_LAST) state_nxt = S_FORCE;
            else                       wait_nxt  = wait_cnt + 4'd1;
          end
        end
        default: state_nxt = S_LOAD;
      endcase
    end
  end

  // SRAM command mux: the granted side drives the port, otherwise idle zeros.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    owner_nxt = OWN_NONE;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_wen;
      mem_ren   = ~cpu_wen;
      if (!cpu_wen) owner_nxt = OWN_CPU;
    end else if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_wen   = ext_wen;
      mem_ren   = ~ext_wen;
      if (!ext_wen) owner_nxt = OWN_EXT;
    end
  end

  // Read return: only the owner of last cycle's read sees the SRAM data.
  always_comb begin
    cpu_rvalid = (rd_owner == OWN_CPU);
    ext_rvalid = (rd_owner == OWN_EXT);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    ext_rdata  = ext_rvalid ? mem_rdata : '0;
  end

  assign dbg_state    = state;
  assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 1-cycle SRAM.
module tb_dmem_arbiter;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 8;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_CPU   = 2'd1;
  localparam logic [1:0] S_FORCE = 2'd2;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              enable;
  logic              cpu_req, cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              ext_req, ext_wen;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen, mem_ren;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        dbg_state;
  logic [3:0]        dbg_wait_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] sram [2**ADDR_W];

  // clock / reset block
  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // behavioural single-port SRAM, read data one cycle after mem_ren
  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= sram[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c_req, input logic c_wen, input logic [ADDR_W-1:0] c_addr,
                       input logic [DATA_W-1:0] c_wd, input logic e_req, input logic e_wen,
                       input logic [ADDR_W-1:0] e_addr, input logic [DATA_W-1:0] e_wd);
    cpu_req = c_req; cpu_wen = c_wen; cpu_addr = c_addr; cpu_wdata = c_wd;
    ext_req = e_req; ext_wen = e_wen; ext_addr = e_addr; ext_wdata = e_wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Both sides read (CPU addr 1, host addr 2) from S_CPU with wait_cnt 0:
  // MAX_WAIT CPU grants, then one forced host grant.
  task automatic contend(input string tag);
    drive(1'b1, 1'b0, 10'd1, '0, 1'b1, 1'b0, 10'd2, '0);
    for (int k = 0; k < MAX_WAIT; k++) begin
      @(negedge clk);
      check({tag, "_wait"},  64'(dbg_wait_cnt), 64'(k));
      check({tag, "_gnt"},   64'(ext_gnt), 64'd0);
      check({tag, "_stall"}, 64'(cpu_stall), 64'd0);
      check({tag, "_maddr"}, 64'(mem_addr), 64'd1);
      tick();
    end
    @(negedge clk);
    check({tag, "_force_state"}, 64'(dbg_state), 64'(S_FORCE));
    check({tag, "_force_gnt"},   64'(ext_gnt), 64'd1);
    check({tag, "_force_stall"}, 64'(cpu_stall), 64'd1);
    check({tag, "_force_maddr"}, 64'(mem_addr), 64'd2);
    check({tag, "_force_ren"},   64'(mem_ren), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) sram[i] = '0;
    mem_rdata = '0;
    arst_n = 1'b1;
    enable = 1'b0;
    idle();
    cpu_req = 1'b1;
    #2;
    check("rst_state",  64'(dbg_state), 64'(S_LOAD));
    check("rst_wait",   64'(dbg_wait_cnt), 64'd0);
    check("rst_crv",    64'(cpu_rvalid), 64'd0);
    check("rst_erv",    64'(ext_rvalid), 64'd0);
    check("rst_crd",    64'(cpu_rdata), 64'd0);
    check("rst_erd",    64'(ext_rdata), 64'd0);
    check("rst_gnt",    64'(ext_gnt), 64'd0);
    check("rst_stall1", 64'(cpu_stall), 64'd1);
    check("rst_wen",    64'(mem_wen), 64'd0);
    check("rst_ren",    64'(mem_ren), 64'd0);
    cpu_req = 1'b0;
    #1;
    check("rst_stall0", 64'(cpu_stall), 64'd0);
    arst_n = 1'b0;
    tick();

    // load mode: host write 5, host read 5, CPU frozen
    drive(1'b1, 1'b0, 10'd9, '0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("ld_w_gnt",   64'(ext_gnt), 64'd1);
    check("ld_w_stall", 64'(cpu_stall), 64'd1);
    check("ld_w_wen",   64'(mem_wen), 64'd1);
    check("ld_w_ren",   64'(mem_ren), 64'd0);
    check("ld_w_addr",  64'(mem_addr), 64'd5);
    check("ld_w_data",  64'(mem_wdata), 64'hDEADBEEF);
    tick();
    drive(1'b1, 1'b0, 10'd9, '0, 1'b1, 1'b0, 10'd5, '0);
    @(negedge clk);
    check("ld_r_gnt",   64'(ext_gnt), 64'd1);
    check("ld_r_ren",   64'(mem_ren), 64'd1);
    check("ld_w_norv",  64'(ext_rvalid), 64'd0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'd1, 32'h11);
    @(negedge clk);
    check("ld_rv",      64'(ext_rvalid), 64'd1);
    check("ld_rdata",   64'(ext_rdata), 64'hDEADBEEF);
    check("ld_crv",     64'(cpu_rvalid), 64'd0);
    check("ld_crd",     64'(cpu_rdata), 64'd0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'd2, 32'h22);
    tick();
    enable = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'd3, 32'h33);
    @(negedge clk);
    check("ld_last_state", 64'(dbg_state), 64'(S_LOAD));
    tick();

    // idle sharing: host read granted immediately in S_CPU
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd3, '0);
    @(negedge clk);
    check("idle_state", 64'(dbg_state), 64'(S_CPU));
    check("idle_gnt",   64'(ext_gnt), 64'd1);
    check("idle_stall", 64'(cpu_stall), 64'd0);
    check("idle_addr",  64'(mem_addr), 64'd3);
    tick();
    idle();
    @(negedge clk);
    check("idle_rv",    64'(ext_rvalid), 64'd1);
    check("idle_rdata", 64'(ext_rdata), 64'h33);
    check("idle_wait",  64'(dbg_wait_cnt), 64'd0);
    tick();

    // routing: CPU read 1 then host read 2 on consecutive cycles
    drive(1'b1, 1'b0, 10'd1, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("rt_c_ren",   64'(mem_ren), 64'd1);
    check("rt_c_addr",  64'(mem_addr), 64'd1);
    check("rt_c_gnt",   64'(ext_gnt), 64'd0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd2, '0);
    @(negedge clk);
    check("rt_crv",     64'(cpu_rvalid), 64'd1);
    check("rt_crd",     64'(cpu_rdata), 64'h11);
    check("rt_erv0",    64'(ext_rvalid), 64'd0);
    check("rt_erd0",    64'(ext_rdata), 64'd0);
    check("rt_e_gnt",   64'(ext_gnt), 64'd1);
    tick();
    idle();
    @(negedge clk);
    check("rt_erv",     64'(ext_rvalid), 64'd1);
    check("rt_erd",     64'(ext_rdata), 64'h22);
    check("rt_crv0",    64'(cpu_rvalid), 64'd0);
    check("rt_crd0",    64'(cpu_rdata), 64'd0);
    tick();

    // write then read same address from the CPU
    drive(1'b1, 1'b1, 10'd7, 32'h77, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("wr_wen",     64'(mem_wen), 64'd1);
    check("wr_wdata",   64'(mem_wdata), 64'h77);
    tick();
    drive(1'b1, 1'b0, 10'd7, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("wr_norv",    64'(cpu_rvalid), 64'd0);
    tick();
    idle();
    @(negedge clk);
    check("rd_after_wr", 64'(cpu_rdata), 64'h77);
    tick();

    // CPU priority with starvation release
    contend("prio");
    tick();
    @(negedge clk);
    check("post_state", 64'(dbg_state), 64'(S_CPU));
    check("post_wait",  64'(dbg_wait_cnt), 64'd0);
    check("post_gnt",   64'(ext_gnt), 64'd0);
    check("post_stall", 64'(cpu_stall), 64'd0);
    check("post_erv",   64'(ext_rvalid), 64'd1);
    check("post_erd",   64'(ext_rdata), 64'h22);
    check("post_crv",   64'(cpu_rvalid), 64'd0);
    tick();
    @(negedge clk);
    check("post2_wait", 64'(dbg_wait_cnt), 64'd1);
    check("post2_crd",  64'(cpu_rdata), 64'h11);
    tick();

    // mode switch with a pending count
    enable = 1'b0;
    @(negedge clk);
    check("ms_state",   64'(dbg_state), 64'(S_CPU));
    check("ms_wait",    64'(dbg_wait_cnt), 64'd2);
    check("ms_gnt",     64'(ext_gnt), 64'd0);
    tick();
    enable = 1'b1;
    @(negedge clk);
    check("ms_load",    64'(dbg_state), 64'(S_LOAD));
    check("ms_lwait",   64'(dbg_wait_cnt), 64'd0);
    check("ms_lgnt",    64'(ext_gnt), 64'd1);
    check("ms_lstall",  64'(cpu_stall), 64'd1);
    tick();
    contend("fresh");
    tick();

    // reset in the middle of a CPU read
    drive(1'b1, 1'b0, 10'd1, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("mr_state",   64'(dbg_state), 64'(S_CPU));
    check("mr_ren",     64'(mem_ren), 64'd1);
    #2;
    arst_n = 1'b1;
    idle();
    #1;
    check("mr_state_l", 64'(dbg_state), 64'(S_LOAD));
    check("mr_ren0",    64'(mem_ren), 64'd0);
    tick();
    check("mr_crv",     64'(cpu_rvalid), 64'd0);
    check("mr_crd",     64'(cpu_rdata), 64'd0);
    check("mr_wen",     64'(mem_wen), 64'd0);
    check("mr_ren1",    64'(mem_ren), 64'd0);
    check("mr_state2",  64'(dbg_state), 64'(S_LOAD));
    arst_n = 1'b0;
    tick();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data SRAM between the CPU MEM-stage access and the external host port. CPU has priority; a starvation counter forces a host grant after MAX_WAIT blocked cycles, stalling the CPU for that cycle. With enable low (load/debug mode) the host owns the memory exclusively. The block also routes the 1-cycle-latency read data back to whichever requester issued the read.

Parameters:
ADDR_W, 10, word address width of data SRAM
DATA_W, 32, data word width
MAX_WAIT, 8, consecutive host-blocked cycles before a forced host grant (1..15)

Ports:
clk  input  1  main clock, rising edge
arst_n  input  1  asynchronous reset, active-high (1 = reset)
enable  input  1  CPU running; 0 = host-exclusive load mode
cpu_req  input  1  MEM stage access request (mem_read or mem_write)
cpu_wen  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU word address
cpu_wdata  input  DATA_W  CPU write data
cpu_stall  output  1  CPU request not served this cycle; pipeline must hold
cpu_rdata  output  DATA_W  read data to CPU
cpu_rvalid  output  1  cpu_rdata valid (cycle after CPU read grant)
ext_req  input  1  host access request
ext_wen  input  1  1 = write, 0 = read
ext_addr  input  ADDR_W  host word address
ext_wdata  input  DATA_W  host write data
ext_gnt  output  1  host access accepted this cycle
ext_rdata  output  DATA_W  read data to host
ext_rvalid  output  1  ext_rdata valid (cycle after host read grant)
mem_addr  output  ADDR_W  SRAM address
mem_wen  output  1  SRAM write enable
mem_ren  output  1  SRAM read enable
mem_wdata  output  DATA_W  SRAM write data
mem_rdata  input  DATA_W  SRAM read data, valid one cycle after mem_ren

Behaviour:
- States: S_CPU (CPU priority), S_FORCE (host priority, one grant), S_LOAD (host exclusive). Reset -> S_LOAD if enable=0 else S_CPU on first edge; reset state itself is S_LOAD.
- Grant is combinational from state and requests; at most one grant per cycle.
- S_CPU: cpu_req=1 -> CPU granted, ext_gnt=0. cpu_req=0 and ext_req=1 -> host granted.
- S_FORCE: ext_req=1 -> host granted, cpu_stall=cpu_req. ext_req dropped -> behaves as S_CPU. Leaves to S_CPU after any cycle.
- S_LOAD: host granted whenever ext_req; cpu_stall=cpu_req (CPU is frozen anyway).
- wait_cnt (4 bit): in S_CPU increments when ext_req=1 and host not granted; clears on any host grant or ext_req=0. wait_cnt reaching MAX_WAIT-1 while still blocked -> next state S_FORCE, wait_cnt cleared.
- enable=0 -> S_LOAD next cycle from any state; enable=1 in S_LOAD -> S_CPU, wait_cnt cleared.
- Granted requester drives mem_addr/mem_wdata; mem_wen=granted & wen; mem_ren=granted & ~wen. No grant: mem_wen=mem_ren=0, mem_addr/mem_wdata=0.
- rd_owner register {none,cpu,ext} captures read owner on the granted cycle; next cycle the owner's rvalid=1 and rdata=mem_rdata; other rdata holds 0. Writes produce no rvalid. Back-to-back reads by alternating owners are allowed; each returns to the correct owner.
- Reset values: state S_LOAD, wait_cnt 0, rd_owner none; outputs cpu_rvalid=0, ext_rvalid=0, cpu_rdata=0, ext_rdata=0, ext_gnt=0, cpu_stall=0 unless cpu_req, mem_wen=mem_ren=0.
- Reset asserted mid-read: pending rvalid dropped, never delivered.
- Writes take effect at grant edge; a read of the same address the next cycle returns new data.

Test Plan:
- Load mode: enable=0, host writes 0xDEADBEEF to addr 5, reads addr 5 -> ext_gnt=1 both cycles, ext_rvalid=1 with 0xDEADBEEF one cycle after read grant; cpu_stall=1 if cpu_req asserted.
- CPU priority: enable=1, cpu_req and ext_req both held, MAX_WAIT=8 -> CPU granted 8 cycles, cpu_stall=1 and ext_gnt=1 on cycle 9, CPU granted on cycle 10.
- Idle sharing: enable=1, cpu_req=0, host reads addr 3 -> host granted immediately, wait_cnt stays 0.
- Routing: CPU read addr 1 (0x11) cycle N, host read addr 2 (0x22) cycle N+1 -> cpu_rvalid/0x11 at N+1, ext_rvalid/0x22 at N+2, no cross-delivery.
- Reset mid-read: CPU read granted, arst_n=1 before next edge -> cpu_rvalid stays 0, state S_LOAD, all mem enables 0.
- Mode switch: enable 0->1 with wait_cnt pending -> S_CPU next cycle, wait_cnt=0, forced grant only after a fresh MAX_WAIT blocked cycles.
